// File: rtl/msrv32_pipe_ctrl_if.sv
// Handshake bundle between the pipeline datapath and its stall/flush controller.
// master drives the status/request side; slave is the controller.
interface msrv32_pipe_ctrl_if #(parameter int STALL_CNT_W = 16);
   logic                   imem_ready_in;
   logic                   dmem_req_in;
   logic                   dmem_ready_in;
   logic                   load_2_in;
   logic [4:0]             rd_addr_2_in;
   logic                   rf_wr_en_2_in;
   logic [4:0]             rs1_addr_1_in;
   logic [4:0]             rs2_addr_1_in;
   logic                   rs1_used_1_in;
   logic                   rs2_used_1_in;
   logic                   branch_taken_in;
   logic                   trap_taken_in;
   logic                   mret_in;
   logic                   stall_clr_in;
   logic                   pc_en_out;
   logic                   reg1_en_out;
   logic                   reg2_en_out;
   logic                   reg1_flush_out;
   logic                   reg2_bubble_out;
   logic [1:0]             state_out;
   logic [STALL_CNT_W-1:0] stall_cnt_out;

   modport master (
      output imem_ready_in, dmem_req_in, dmem_ready_in, load_2_in, rd_addr_2_in,
             rf_wr_en_2_in, rs1_addr_1_in, rs2_addr_1_in, rs1_used_1_in,
             rs2_used_1_in, branch_taken_in, trap_taken_in, mret_in, stall_clr_in,
      input  pc_en_out, reg1_en_out, reg2_en_out, reg1_flush_out, reg2_bubble_out,
             state_out, stall_cnt_out
   );

   modport slave (
      input  imem_ready_in, dmem_req_in, dmem_ready_in, load_2_in, rd_addr_2_in,
             rf_wr_en_2_in, rs1_addr_1_in, rs2_addr_1_in, rs1_used_1_in,
             rs2_used_1_in, branch_taken_in, trap_taken_in, mret_in, stall_clr_in,
      output pc_en_out, reg1_en_out, reg2_en_out, reg1_flush_out, reg2_bubble_out,
             state_out, stall_cnt_out
   );
endinterface

// File: rtl/msrv32_pipe_ctrl.sv
// Pipeline controller: PC/register-block enables, flush and bubble generation,
// plus a saturating count of cycles in which the PC did not advance.
module msrv32_pipe_ctrl #(
   parameter int STALL_CNT_W = 16
) (
   input  logic              clk_in,
   input  logic              reset_n_in,
   msrv32_pipe_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      RUN       = 2'b00,
      DMEM_WAIT = 2'b01,
      REDIRECT  = 2'b10,
      UNUSED    = 2'b11
   } state_t;

   state_t                 r_state;
   state_t                 w_next;
   logic [STALL_CNT_W-1:0] r_cnt;
   logic                   w_redir;
   logic                   w_hazard;
   logic                   w_pc_en;
   logic                   w_reg1_en;
   logic                   w_reg2_en;
   logic                   w_flush;
   logic                   w_bubble;

   assign w_redir  = bus.branch_taken_in | bus.trap_taken_in | bus.mret_in;
   assign w_hazard = bus.load_2_in & bus.rf_wr_en_2_in & (bus.rd_addr_2_in != 5'd0) &
                     ((bus.rs1_used_1_in & (bus.rs1_addr_1_in == bus.rd_addr_2_in)) |
                      (bus.rs2_used_1_in & (bus.rs2_addr_1_in == bus.rd_addr_2_in)));

   always_ff @(posedge clk_in or negedge reset_n_in) begin
      if (!reset_n_in) r_state <= RUN;
      else             r_state <= w_next;
   end

   always_comb begin
      w_next    = RUN;
      w_pc_en   = 1'b1;
      w_reg1_en = 1'b1;
      w_reg2_en = 1'b1;
      w_flush   = 1'b0;
      w_bubble  = 1'b0;
      if (!reset_n_in) begin
         w_pc_en   = 1'b0;
         w_reg1_en = 1'b0;
         w_reg2_en = 1'b0;
         w_flush   = 1'b1;
         w_bubble  = 1'b1;
      end else if (r_state == REDIRECT) begin
         w_flush = 1'b1;
      end else if (r_state == DMEM_WAIT && !bus.dmem_ready_in) begin
         w_next    = DMEM_WAIT;
         w_pc_en   = 1'b0;
         w_reg1_en = 1'b0;
         w_reg2_en = 1'b0;
      end else if (w_redir) begin
         w_next  = REDIRECT;
         w_flush = 1'b1;
      // In DMEM_WAIT this arm can't fire: dmem_ready_in is already 1 here.
      end else if (bus.dmem_req_in && !bus.dmem_ready_in) begin
         w_next    = DMEM_WAIT;
         w_pc_en   = 1'b0;
         w_reg1_en = 1'b0;
         w_reg2_en = 1'b0;
      end else if (w_hazard) begin
         w_pc_en   = 1'b0;
         w_reg1_en = 1'b0;
         w_bubble  = 1'b1;
      end else if (!bus.imem_ready_in) begin
         w_pc_en = 1'b0;
         w_flush = 1'b1;
      end
   end

   always_ff @(posedge clk_in or negedge reset_n_in) begin
      if (!reset_n_in)                    r_cnt <= '0;
      else if (bus.stall_clr_in)          r_cnt <= '0;
      else if (!w_pc_en && r_cnt != '1)   r_cnt <= r_cnt + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
   end

   assign bus.pc_en_out       = w_pc_en;
   assign bus.reg1_en_out     = w_reg1_en;
   assign bus.reg2_en_out     = w_reg2_en;
   assign bus.reg1_flush_out  = w_flush;
   assign bus.reg2_bubble_out = w_bubble;
   assign bus.state_out       = r_state;
   assign bus.stall_cnt_out   = r_cnt;

endmodule

// File: tb/tb_msrv32_pipe_ctrl.sv
// Directed bench for msrv32_pipe_ctrl: RUN-rule table plus multi-cycle sequences,
// with a second instance at STALL_CNT_W=4 for saturation and reset cases.
module tb_msrv32_pipe_ctrl;

   logic clk;
   logic rst_a_n;
   logic rst_b_n;
   int   tests;
   int   fails;

   msrv32_pipe_ctrl_if #(.STALL_CNT_W(16)) bus_a ();
   msrv32_pipe_ctrl_if #(.STALL_CNT_W(4))  bus_b ();

   msrv32_pipe_ctrl #(.STALL_CNT_W(16)) dut_a (.clk_in(clk), .reset_n_in(rst_a_n), .bus(bus_a));
   msrv32_pipe_ctrl #(.STALL_CNT_W(4))  dut_b (.clk_in(clk), .reset_n_in(rst_b_n), .bus(bus_b));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       imem, dreq, drdy, ld, wen;
      logic [4:0] rd, rs1, rs2;
      logic       u1, u2, br, tr, mr;
      logic [4:0] exp;   // {pc_en, reg1_en, reg2_en, reg1_flush, reg2_bubble}
      logic [1:0] nst;
   } vec_t;

   vec_t vecs[17];
   vec_t idle;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drv_a(input vec_t v);
      bus_a.imem_ready_in   = v.imem;
      bus_a.dmem_req_in     = v.dreq;
      bus_a.dmem_ready_in   = v.drdy;
      bus_a.load_2_in       = v.ld;
      bus_a.rf_wr_en_2_in   = v.wen;
      bus_a.rd_addr_2_in    = v.rd;
      bus_a.rs1_addr_1_in   = v.rs1;
      bus_a.rs2_addr_1_in   = v.rs2;
      bus_a.rs1_used_1_in   = v.u1;
      bus_a.rs2_used_1_in   = v.u2;
      bus_a.branch_taken_in = v.br;
      bus_a.trap_taken_in   = v.tr;
      bus_a.mret_in         = v.mr;
   endtask

   function automatic logic [4:0] outs_a();
      return {bus_a.pc_en_out, bus_a.reg1_en_out, bus_a.reg2_en_out,
              bus_a.reg1_flush_out, bus_a.reg2_bubble_out};
   endfunction

   function automatic logic [4:0] outs_b();
      return {bus_b.pc_en_out, bus_b.reg1_en_out, bus_b.reg2_en_out,
              bus_b.reg1_flush_out, bus_b.reg2_bubble_out};
   endfunction

   initial begin
      vec_t v;
      tests = 0;
      fails = 0;
      idle  = '{1'b1,1'b0,1'b1,1'b0,1'b0, 5'd0,5'd0,5'd0, 1'b0,1'b0,1'b0,1'b0,1'b0, 5'b11100,2'b00};
      //           imem dreq drdy ld  wen    rd    rs1   rs2   u1  u2  br  tr  mr    expect   nst
      vecs[0]  = '{1'b1,1'b0,1'b0,1'b0,1'b0, 5'd0,5'd0,5'd0, 1'b0,1'b0,1'b0,1'b0,1'b0, 5'b11100,2'b00};
      vecs[1]  = '{1'b0,1'b0,1'b0,1'b0,1'b0, 5'd0,5'd0,5'd0, 1'b0,1'b0,1'b0,1'b0,1'b0, 5'b01110,2'b00};
      vecs[2]  = '{1'b1,1'b0,1'b0,1'b1,1'b1, 5'd5,5'd5,5'd0, 1'b1,1'b0,1'b0,1'b0,1'b0, 5'b00101,2'b00};
      vecs[3]  = '{1'b1,1'b0,1'b0,1'b1,1'b1, 5'd0,5'd0,5'd0, 1'b1,1'b0,1'b0,1'b0,1'b0, 5'b11100,2'b00};
      vecs[4]  = '{1'b1,1'b0,1'b0,1'b1,1'b1, 5'd7,5'd1,5'd7, 1'b1,1'b1,1'b0,1'b0,1'b0, 5'b00101,2'b00};
      vecs[5]  = '{1'b1,1'b0,1'b0,1'b1,1'b1, 5'd7,5'd1,5'd7, 1'b1,1'b0,1'b0,1'b0,1'b0, 5'b11100,2'b00};
      vecs[6]  = '{1'b1,1'b0,1'b0,1'b1,1'b0, 5'd5,5'd5,5'd0, 1'b1,1'b0,1'b0,1'b0,1'b0, 5'b11100,2'b00};
      vecs[7]  = '{1'b1,1'b0,1'b0,1'b0,1'b1, 5'd5,5'd5,5'd0, 1'b1,1'b0,1'b0,1'b0,1'b0, 5'b11100,2'b00};
      vecs[8]  = '{1'b1,1'b1,1'b0,1'b0,1'b0, 5'd0,5'd0,5'd0, 1'b0,1'b0,1'b0,1'b0,1'b0, 5'b00000,2'b01};
      vecs[9]  = '{1'b1,1'b1,1'b1,1'b0,1'b0, 5'd0,5'd0,5'd0, 1'b0,1'b0,1'b0,1'b0,1'b0, 5'b11100,2'b00};
      vecs[10] = '{1'b1,1'b0,1'b0,1'b0,1'b0, 5'd0,5'd0,5'd0, 1'b0,1'b0,1'b1,1'b0,1'b0, 5'b11110,2'b10};
      vecs[11] = '{1'b1,1'b0,1'b0,1'b0,1'b0, 5'd0,5'd0,5'd0, 1'b0,1'b0,1'b0,1'b1,1'b0, 5'b11110,2'b10};
      vecs[12] = '{1'b1,1'b0,1'b0,1'b0,1'b0, 5'd0,5'd0,5'd0, 1'b0,1'b0,1'b0,1'b0,1'b1, 5'b11110,2'b10};
      vecs[13] = '{1'b1,1'b1,1'b0,1'b0,1'b0, 5'd0,5'd0,5'd0, 1'b0,1'b0,1'b1,1'b0,1'b0, 5'b11110,2'b10};
      vecs[14] = '{1'b1,1'b1,1'b0,1'b1,1'b1, 5'd5,5'd5,5'd0, 1'b1,1'b0,1'b0,1'b0,1'b0, 5'b00000,2'b01};
      vecs[15] = '{1'b0,1'b0,1'b0,1'b1,1'b1, 5'd5,5'd5,5'd0, 1'b1,1'b0,1'b0,1'b0,1'b0, 5'b00101,2'b00};
      vecs[16] = '{1'b1,1'b0,1'b0,1'b1,1'b1, 5'd5,5'd5,5'd0, 1'b1,1'b0,1'b0,1'b0,1'b1, 5'b11110,2'b10};

      rst_a_n = 1'b0;
      rst_b_n = 1'b0;
      drv_a(idle);
      bus_a.stall_clr_in = 1'b0;
      bus_b.imem_ready_in = 1'b1; bus_b.dmem_req_in = 1'b0; bus_b.dmem_ready_in = 1'b1;
      bus_b.load_2_in = 1'b0; bus_b.rf_wr_en_2_in = 1'b0; bus_b.rd_addr_2_in = 5'd0;
      bus_b.rs1_addr_1_in = 5'd0; bus_b.rs2_addr_1_in = 5'd0;
      bus_b.rs1_used_1_in = 1'b0; bus_b.rs2_used_1_in = 1'b0;
      bus_b.branch_taken_in = 1'b0; bus_b.trap_taken_in = 1'b0; bus_b.mret_in = 1'b0;
      bus_b.stall_clr_in = 1'b0;

      // reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_outs", 32'(outs_a()), 32'b00011);
      chk("rst_state", 32'(bus_a.state_out), 32'd0);
      chk("rst_cnt", 32'(bus_a.stall_cnt_out), 32'd0);

      @(negedge clk);
      rst_a_n = 1'b1;
      rst_b_n = 1'b1;
      #1;
      chk("post_rst_outs", 32'(outs_a()), 32'b11100);

      // RUN-rule table, each vector followed by one idle cycle back to RUN
      for (int i = 0; i < 17; i++) begin
         @(negedge clk);
         drv_a(vecs[i]);
         #1;
         chk($sformatf("vec%0d_outs", i), 32'(outs_a()), 32'(vecs[i].exp));
         @(posedge clk);
         #1;
         chk($sformatf("vec%0d_nst", i), 32'(bus_a.state_out), 32'(vecs[i].nst));
         @(negedge clk);
         drv_a(idle);
         @(posedge clk);
         #1;
         chk($sformatf("vec%0d_back", i), 32'(bus_a.state_out), 32'd0);
      end

      // load-use hazard: single bubble cycle, counted once
      @(negedge clk);
      bus_a.stall_clr_in = 1'b1;
      @(posedge clk);
      #1;
      chk("clr_cnt", 32'(bus_a.stall_cnt_out), 32'd0);
      @(negedge clk);
      bus_a.stall_clr_in = 1'b0;
      drv_a(vecs[2]);
      #1;
      chk("haz_outs", 32'(outs_a()), 32'b00101);
      @(negedge clk);
      drv_a(idle);
      #1;
      chk("haz_after_outs", 32'(outs_a()), 32'b11100);
      chk("haz_cnt", 32'(bus_a.stall_cnt_out), 32'd1);

      // data wait for 3 cycles, redirect ignored while waiting
      @(negedge clk);
      bus_a.stall_clr_in = 1'b1;
      @(negedge clk);
      bus_a.stall_clr_in = 1'b0;
      v = idle; v.dreq = 1'b1; v.drdy = 1'b0;
      drv_a(v);
      #1;
      chk("dw1_outs", 32'(outs_a()), 32'b00000);
      chk("dw1_state", 32'(bus_a.state_out), 32'd0);
      @(negedge clk);
      #1;
      chk("dw2_outs", 32'(outs_a()), 32'b00000);
      chk("dw2_state", 32'(bus_a.state_out), 32'd1);
      @(negedge clk);
      bus_a.branch_taken_in = 1'b1;
      #1;
      chk("dw3_outs", 32'(outs_a()), 32'b00000);
      chk("dw3_state", 32'(bus_a.state_out), 32'd1);
      @(negedge clk);
      bus_a.branch_taken_in = 1'b0;
      bus_a.dmem_ready_in = 1'b1;
      #1;
      chk("dw_rel_outs", 32'(outs_a()), 32'b11100);
      chk("dw_rel_state", 32'(bus_a.state_out), 32'd1);
      chk("dw_cnt", 32'(bus_a.stall_cnt_out), 32'd3);
      @(negedge clk);
      drv_a(idle);
      #1;
      chk("dw_done_state", 32'(bus_a.state_out), 32'd0);

      // branch then trap during REDIRECT
      @(negedge clk);
      v = idle; v.br = 1'b1;
      drv_a(v);
      #1;
      chk("br_flush1", 32'(outs_a()), 32'b11110);
      @(negedge clk);
      v = idle; v.tr = 1'b1; v.dreq = 1'b1; v.drdy = 1'b0;
      drv_a(v);
      #1;
      chk("br_state", 32'(bus_a.state_out), 32'd2);
      chk("br_flush2", 32'(outs_a()), 32'b11110);
      @(negedge clk);
      drv_a(idle);
      #1;
      chk("br_ret_state", 32'(bus_a.state_out), 32'd0);

      // 4-bit counter: saturation, clear priority, reset mid-DMEM_WAIT
      @(negedge clk);
      bus_b.imem_ready_in = 1'b0;
      repeat (20) @(negedge clk);
      #1;
      chk("sat_cnt", 32'(bus_b.stall_cnt_out), 32'd15);
      bus_b.stall_clr_in = 1'b1;
      @(negedge clk);
      #1;
      chk("sat_clr", 32'(bus_b.stall_cnt_out), 32'd0);
      bus_b.stall_clr_in = 1'b0;
      bus_b.imem_ready_in = 1'b1;
      bus_b.dmem_req_in = 1'b1;
      bus_b.dmem_ready_in = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      chk("b_dw_state", 32'(bus_b.state_out), 32'd1);
      chk("b_dw_cnt", 32'(bus_b.stall_cnt_out), 32'd2);
      #2;
      rst_b_n = 1'b0;
      #1;
      chk("b_rst_state", 32'(bus_b.state_out), 32'd0);
      chk("b_rst_cnt", 32'(bus_b.stall_cnt_out), 32'd0);
      chk("b_rst_outs", 32'(outs_b()), 32'b00011);
      @(negedge clk);
      bus_b.dmem_req_in = 1'b0;
      bus_b.dmem_ready_in = 1'b1;
      rst_b_n = 1'b1;
      @(posedge clk);
      #1;
      chk("b_rel_state", 32'(bus_b.state_out), 32'd0);
      chk("b_rel_outs", 32'(outs_b()), 32'b11100);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/msrv32_pipe_ctrl.md
MSRV32_PIPE_CTRL -- requirements
Module: msrv32_pipe_ctrl

Interface
REQ-001 SHALL have parameter: STALL_CNT_W, 16, width of the stall-cycle counter.
REQ-002 SHALL have port: clk_in  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: reset_n_in  input  1  asynchronous active-low reset.
REQ-004 SHALL have port: imem_ready_in  input  1  fetched instruction valid this cycle.
REQ-005 SHALL have port: dmem_req_in  input  1  stage-2 instruction issues a load or store.
REQ-006 SHALL have port: dmem_ready_in  input  1  data memory completes the access this cycle.
REQ-007 SHALL have port: load_2_in  input  1  stage-2 instruction is a load.
REQ-008 SHALL have ports: rd_addr_2_in  input  5  stage-2 destination register; rf_wr_en_2_in  input  1  stage-2 register write enable.
REQ-009 SHALL have ports: rs1_addr_1_in and rs2_addr_1_in  input  5  stage-1 source registers; rs1_used_1_in and rs2_used_1_in  input  1  source actually read.
REQ-010 SHALL have ports: branch_taken_in, trap_taken_in, mret_in  input  1 each  control-flow redirect requests.
REQ-011 SHALL have port: stall_clr_in  input  1  synchronous clear of the stall counter.
REQ-012 SHALL have ports: pc_en_out, reg1_en_out, reg2_en_out  output  1 each  PC, register block 1 and register block 2 load enables.
REQ-013 SHALL have ports: reg1_flush_out  output  1  load a NOP into register block 1; reg2_bubble_out  output  1  load a bubble (rf_wr_en=0, csr_wr_en=0, wb_mux_sel=WB_ALU) into register block 2.
REQ-014 SHALL have ports: state_out  output  2  current FSM state; stall_cnt_out  output  STALL_CNT_W  stall-cycle count.

Function
REQ-015 SHALL implement FSM states RUN=00, DMEM_WAIT=01, REDIRECT=10; code 11 SHALL behave as RUN and go to RUN next cycle.
REQ-016 SHALL drive all enable, flush and bubble outputs combinationally from the current state and inputs, so they take effect in the same cycle.
REQ-017 SHALL define redir = branch_taken_in | trap_taken_in | mret_in.
REQ-018 SHALL define hazard = load_2_in & rf_wr_en_2_in & (rd_addr_2_in != 0) & ((rs1_used_1_in & rs1_addr_1_in == rd_addr_2_in) | (rs2_used_1_in & rs2_addr_1_in == rd_addr_2_in)).
REQ-019 SHALL, in RUN, evaluate rules in this priority order: redirect, data wait, hazard, fetch wait, normal.
REQ-020 Redirect rule SHALL drive pc_en=1, reg1_en=1, reg1_flush=1, reg2_en=1, reg2_bubble=0, with next state REDIRECT.
REQ-021 Data-wait rule (dmem_req_in & !dmem_ready_in) SHALL drive all enables 0 and flush/bubble 0, with next state DMEM_WAIT.
REQ-022 Hazard rule SHALL drive pc_en=0, reg1_en=0, reg2_en=1, reg2_bubble=1, and remain in RUN.
REQ-023 Fetch-wait rule (!imem_ready_in) SHALL drive pc_en=0, reg1_en=1, reg1_flush=1, reg2_en=1, and remain in RUN.
REQ-024 Normal rule SHALL drive all enables 1 and flush/bubble 0.
REQ-025 DMEM_WAIT SHALL hold all enables 0 while dmem_ready_in=0 and ignore redir.
REQ-026 On dmem_ready_in=1, DMEM_WAIT SHALL apply the RUN rules in the same cycle, with the data-wait rule excluded.
REQ-027 REDIRECT SHALL drive pc_en=1, reg1_en=1, reg1_flush=1, reg2_en=1, reg2_bubble=0, ignore redir and dmem inputs, and return to RUN.
REQ-028 The stall counter SHALL increment by 1 on each cycle with pc_en_out=0.
REQ-029 The stall counter SHALL saturate at all-ones.
REQ-030 stall_clr_in SHALL take priority over increment and force the counter to 0 on the next edge.

Reset
REQ-031 While reset_n_in=0, state SHALL be RUN and stall_cnt_out SHALL be 0, asynchronously.
REQ-032 While reset_n_in=0, outputs SHALL be forced to pc_en=0, reg1_en=0, reg2_en=0, reg1_flush=1, reg2_bubble=1, state_out=00.
REQ-033 Reset asserted in any state, including mid-DMEM_WAIT, SHALL abandon that state immediately.
REQ-034 After release, the first edge SHALL evaluate the RUN rules.

Verification
REQ-035 Bench SHALL cover: load_2=1, rf_wr_en_2=1, rd_addr_2=5, rs1_addr_1=5, rs1_used=1 -> one cycle of pc_en=0, reg2_bubble=1; next cycle all enables 1; stall_cnt=1.
REQ-036 Bench SHALL cover: same as REQ-035 with rd_addr_2=0 -> no stall.
REQ-037 Bench SHALL cover: dmem_req=1, dmem_ready=0 for 3 cycles then 1 -> state 01 for 3 cycles, enables 0, stall_cnt=3; release cycle enables 1, then state 00.
REQ-038 Bench SHALL cover: branch_taken=1 in RUN -> reg1_flush=1 for two consecutive cycles (RUN then REDIRECT); trap_taken asserted during REDIRECT is ignored.
REQ-039 Bench SHALL cover: redir=1 together with dmem_req=1, dmem_ready=0 -> redirect wins, next state 10.
REQ-040 Bench SHALL cover: STALL_CNT_W=4 with 20 stall cycles -> stall_cnt_out holds 15; stall_clr_in=1 -> 0 on the next edge; reset_n_in pulled low mid-DMEM_WAIT -> state 00 and count 0 immediately.
